fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one `fp_mul` (8x8 -> 16-bit product datapath) among `NUM_REQ` independent requesters. It sits between the modular-arithmetic clients (Barrett reduction front ends, NTT butterflies) and the single multiplier instance. It grants at most one operand pair per cycle and returns each product tagged with the requester index, under a single valid/ready response channel.

## Interface
- `NUM_REQ`, 4, number of requesters; must be >= 2.
- `DATA_WIDTH`, 8, operand width. The product is 2*`DATA_WIDTH`; `fp_mul` is instantiated at this width.
- `ID_WIDTH`, 2, width of requester index; must satisfy 2^`ID_WIDTH` >= `NUM_REQ`.
- Clock and reset: one clock; reset is synchronous and active-high (ports `clk` and `reset`).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_a`  in  `NUM_REQ`*`DATA_WIDTH`  packed operand a; requester i occupies bits [i*W +: W].
- `req_b`  in  `NUM_REQ`*`DATA_WIDTH`  packed operand b, same packing.
- `req_ready`  out  `NUM_REQ`  one-hot-or-zero grant; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  1  product available.
- `rsp_ready`  in  1  consumer accepts product.
- `rsp_data`  out  2*`DATA_WIDTH`  product a*b.
- `rsp_id`  out  `ID_WIDTH`  index of the requester that issued the operands.
- `busy`  out  1  high while either pipeline stage holds a valid entry.

## Operation
- Stage S1 is the operand register: a, b, id, valid. Stage S2 is the product register: `fp_mul`(S1.a, S1.b), id, valid. S2 drives `rsp_*` directly.
- Stall rule: S2 advances when `!S2.valid || rsp_ready`. S1 advances when `!S1.valid || S2 advances`. The arbiter may grant only when S1 advances (`can_accept`).
- Arbitration: a round-robin pointer `ptr` holds the highest-priority index. The search order is ptr, ptr+1, ..., wrapping modulo `NUM_REQ`. The first requester with `req_valid` high gets `req_ready`, provided `can_accept` is high.
- On each grant, `ptr` becomes granted index + 1, wrapping to 0 after `NUM_REQ`-1. Without a grant, `ptr` holds.
- `req_ready` is combinational from `req_valid`, `ptr` and `can_accept`. Requesters must not make `req_valid` depend on `req_ready`. A requester holds its operands stable while valid and not granted.
- Arithmetic: the full unsigned product, with no truncation. The maximum value is (2^W-1)^2 = 65025 for W=8.
- Outputs are ordered strictly in grant order, with no reordering.
- Reset values: `ptr`=0, S1.valid=0, S2.valid=0, `rsp_valid`=0, `busy`=0, `req_ready`=0. `rsp_data` and `rsp_id` are 0 (data registers are also reset).
- Reset mid-operation: any in-flight S1/S2 entries are discarded and never presented. While `reset` is high, `req_ready` is 0. A requester whose transfer coincides with a reset cycle has not been accepted.
- Simultaneous events: in one cycle S2 may drain (`rsp_valid`&&`rsp_ready`), S1 may move to S2, and a new grant may load S1. Full throughput is 1 product/cycle.
- Full condition: S2 valid with `rsp_ready` low, and S1 valid. Then `can_accept`=0, all `req_ready`=0, and `ptr` holds.

## Timing
- Latency: a transfer accepted at edge k appears with `rsp_valid`=1 after edge k+1 (2-cycle accept-to-response) when there is no backpressure.
- `rsp_valid`, `rsp_data` and `rsp_id` are registered. They remain stable while `rsp_valid && !rsp_ready`.
- `busy` is registered, equal to S1.valid | S2.valid.
- Critical path: S1 register -> `fp_mul` -> S2 register. No combinational path exists from `rsp_ready` to `rsp_data`. A path from `rsp_ready` to `req_ready` exists by design.
- One grant per cycle at most. The grant becomes visible combinationally in the same cycle that `req_valid` is seen.

## Test plan
- Single requester 0: a=2,b=1 -> rsp_data=2, rsp_id=0 two cycles after acceptance. Then a=1,b=1 -> 1. Then a=21,b=11 -> 231. Then a=210,b=110 -> 23100. Responses arrive in order, back to back.
- All 4 requesters valid continuously from reset, with requester i issuing a=i+1, b=10. Grant order is 0,1,2,3,0,...; rsp_id follows 0,1,2,3 with data 10,20,30,40; one response per cycle.
- Fairness: requesters 1 and 3 always valid, others idle, `ptr` starting at 0. Grants alternate 1,3,1,3, and neither requester is starved for more than 1 cycle.
- Backpressure: `rsp_ready`=0 for 5 cycles with requesters 0 to 2 valid. Exactly two operations are accepted, then all `req_ready` go low. `rsp_data`/`rsp_id` are held stable. Releasing `rsp_ready` drains the pipeline in order and grants resume.
- Extremes: a=255,b=255 -> 65025. a=0,b=200 -> 0. a=255,b=1 -> 255.
- Reset mid-operation: accept two operations, then assert `reset` for 1 cycle before any response. Afterwards `rsp_valid`=0, `busy`=0 and `ptr`=0. No stale product appears, and the next operation a=3,b=7 returns 21 with the correct id.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one two-stage fp_mul pipeline among NUM_REQ requesters
// fp_mul is the shared combinational multiplier; fp_mul_arbiter wraps it with operand/product registers.

module fp_mul #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    assign p = a * b;
endmodule

module fp_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [2*DATA_WIDTH-1:0]       rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          busy
);
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_WIDTH-1:0]     s1_id_q, s1_id_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [2*DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [ID_WIDTH-1:0]     s2_id_q, s2_id_d;
    logic                    busy_q, busy_d;

    logic                    s2_adv, s1_adv, can_accept;
    logic                    grant_any;
    logic [ID_WIDTH-1:0]     grant_id;
    logic [DATA_WIDTH-1:0]   grant_a, grant_b;
    logic [2*DATA_WIDTH-1:0] product;
    int                      idx;

    fp_mul #(.WIDTH(DATA_WIDTH)) u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (product)
    );

    always_comb begin
        s2_adv     = !s2_valid_q || rsp_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        can_accept = s1_adv && !reset;
    end

    // Search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        grant_a   = '0;
        grant_b   = '0;
        ptr_d     = ptr_q;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (can_accept && !grant_any && req_valid[idx]) begin
                grant_any      = 1'b1;
                req_ready[idx] = 1'b1;
                grant_id       = ID_WIDTH'(idx);
                grant_a        = req_a[idx*DATA_WIDTH +: DATA_WIDTH];
                grant_b        = req_b[idx*DATA_WIDTH +: DATA_WIDTH];
                ptr_d          = (idx == NUM_REQ - 1) ? '0 : ID_WIDTH'(idx + 1);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        if (s1_adv) begin
            s1_valid_d = grant_any;
            if (grant_any) begin
                s1_a_d  = grant_a;
                s1_b_d  = grant_b;
                s1_id_d = grant_id;
            end
        end
        // Data only loads with a real entry so rsp_data stays put across bubbles.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = product;
                s2_id_d   = s1_id_q;
            end
        end
        busy_d = s1_valid_d | s2_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            busy_q     <= busy_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_data_q;
    assign rsp_id    = s2_id_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - scoreboard bench for fp_mul_arbiter
module tb_fp_mul_arbiter;
    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    fp_mul_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    int          rsp_cyc[$];
    logic [15:0] src_q [4][$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          lat_chk  = 1'b0;
    logic [3:0]  smp_ready;
    logic        smp_rsp_valid;
    logic [15:0] smp_data;
    logic [1:0]  smp_id;

    function automatic bit src_pending();
        bit p = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    // One clock: drive requester heads, sample at negedge, log accepts and score responses.
    task automatic step();
        exp_t        e;
        logic [15:0] pa, pb;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]     = (src_q[i].size() > 0);
            req_a[i*8 +: 8]  = req_valid[i] ? src_q[i][0][15:8] : 8'h0;
            req_b[i*8 +: 8]  = req_valid[i] ? src_q[i][0][7:0]  : 8'h0;
        end
        @(negedge clk);
        cyc++;
        smp_ready     = req_ready;
        smp_rsp_valid = rsp_valid;
        smp_data      = rsp_data;
        smp_id        = rsp_id;
        n_checks++;
        if ($countones(req_ready) > 1) begin
            n_fail++;
            $display("FAIL req_ready_onehot: got %b required at most one bit", req_ready);
        end
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pa     = {8'h0, src_q[i][0][15:8]};
                    pb     = {8'h0, src_q[i][0][7:0]};
                    e.id   = 2'(i);
                    e.data = pa * pb;
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                    grant_log.push_back(i);
                    void'(src_q[i].pop_front());
                end
            end
        end
        if (rsp_valid && rsp_ready) begin
            rsp_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got data %0d id %0d required no response", rsp_data, rsp_id);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e.data || rsp_id !== e.id) begin
                    n_fail++;
                    $display("FAIL rsp_match: got data %0d id %0d required data %0d id %0d",
                             rsp_data, rsp_id, e.data, e.id);
                end
                if (lat_chk) begin
                    n_checks++;
                    if (cyc - e.cyc != 2) begin
                        n_fail++;
                        $display("FAIL rsp_latency: got %0d cycles required 2", cyc - e.cyc);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((src_pending() || exp_q.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d cycles pending %0d required below %0d",
                     n, exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        rsp_ready = 1'b1;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        grant_log.delete();
        rsp_cyc.delete();
    endtask

    task automatic check_grants(input string name, input int exp_g[$]);
        n_checks++;
        if (grant_log.size() != exp_g.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d grants required %0d", name, grant_log.size(), exp_g.size());
        end else begin
            for (int i = 0; i < exp_g.size(); i++) begin
                if (grant_log[i] != exp_g[i]) begin
                    n_fail++;
                    $display("FAIL %s_order: grant %0d got %0d required %0d", name, i, grant_log[i], exp_g[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) src_q[i].push_back(16'h0101);
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (smp_ready !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_req_ready: got %b required 0000", smp_ready);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        req_valid = 4'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 16'h0 || rsp_id !== 2'h0 || req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: got valid %b busy %b data %0d id %0d ready %b required all zero",
                     rsp_valid, busy, rsp_data, rsp_id, req_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        lat_chk = 1'b1;
        src_q[0].push_back({8'd2, 8'd1});
        src_q[0].push_back({8'd1, 8'd1});
        src_q[0].push_back({8'd21, 8'd11});
        src_q[0].push_back({8'd210, 8'd110});
        run_idle(40);
        n_checks++;
        if (rsp_cyc.size() != 4 || rsp_cyc[3] - rsp_cyc[0] != 3) begin
            n_fail++;
            $display("FAIL single_back_to_back: got %0d responses required 4 in consecutive cycles", rsp_cyc.size());
        end
    endtask

    task automatic test_all4();
        do_reset();
        lat_chk = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) src_q[i].push_back({8'(i + 1), 8'd10});
        run_idle(60);
        check_grants("all4", '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3});
        n_checks++;
        if (rsp_cyc.size() != 12 || rsp_cyc[11] - rsp_cyc[0] != 11) begin
            n_fail++;
            $display("FAIL all4_throughput: got %0d responses required 12 at one per cycle", rsp_cyc.size());
        end
    endtask

    task automatic test_fairness();
        do_reset();
        lat_chk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src_q[1].push_back({8'(k + 3), 8'd5});
            src_q[3].push_back({8'(k + 7), 8'd9});
        end
        run_idle(60);
        check_grants("fair", '{1, 3, 1, 3, 1, 3, 1, 3});
    endtask

    task automatic test_backpressure();
        logic [15:0] held_data;
        logic [1:0]  held_id;
        do_reset();
        lat_chk   = 1'b0;
        rsp_ready = 1'b0;
        held_data = '0;
        held_id   = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) src_q[i].push_back({8'(i + 5), 8'(k + 3)});
        for (int c = 0; c < 5; c++) begin
            step();
            if (c >= 2) begin
                n_checks++;
                if (smp_ready !== 4'b0) begin
                    n_fail++;
                    $display("FAIL bp_req_ready: cycle %0d got %b required 0000", c, smp_ready);
                end
            end
            if (c == 2) begin
                held_data = smp_data;
                held_id   = smp_id;
                n_checks++;
                if (smp_rsp_valid !== 1'b1 || smp_data !== 16'd15 || smp_id !== 2'd0) begin
                    n_fail++;
                    $display("FAIL bp_first_rsp: got valid %b data %0d id %0d required 1 15 0",
                             smp_rsp_valid, smp_data, smp_id);
                end
            end else if (c > 2) begin
                n_checks++;
                if (smp_rsp_valid !== 1'b1 || smp_data !== held_data || smp_id !== held_id) begin
                    n_fail++;
                    $display("FAIL bp_hold: got valid %b data %0d id %0d required 1 %0d %0d",
                             smp_rsp_valid, smp_data, smp_id, held_data, held_id);
                end
            end
        end
        check_grants("bp_stall", '{0, 1});
        rsp_ready = 1'b1;
        run_idle(60);
        check_grants("bp_resume", '{0, 1, 2, 0, 1, 2});
    endtask

    task automatic test_extremes();
        do_reset();
        lat_chk = 1'b1;
        src_q[2].push_back({8'd255, 8'd255});
        src_q[2].push_back({8'd0, 8'd200});
        src_q[2].push_back({8'd255, 8'd1});
        run_idle(40);
        n_checks++;
        if (rsp_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL extremes_count: got %0d responses required 3", rsp_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_chk   = 1'b0;
        rsp_ready = 1'b0;
        src_q[0].push_back({8'd5, 8'd6});
        src_q[1].push_back({8'd7, 8'd8});
        step();
        step();
        check_grants("mid_pre", '{0, 1});
        src_q[3].push_back({8'd9, 8'd9});
        reset = 1'b1;
        step();
        n_checks++;
        if (smp_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b required 0000", smp_ready);
        end
        reset = 1'b0;
        src_q[3].delete();
        exp_q.delete();
        grant_log.delete();
        rsp_cyc.delete();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_post_reset: got valid %b busy %b required 0 0", rsp_valid, busy);
        end
        rsp_ready = 1'b1;
        lat_chk   = 1'b1;
        src_q[0].push_back({8'd3, 8'd7});
        src_q[3].push_back({8'd4, 8'd5});
        run_idle(40);
        check_grants("mid_ptr", '{0, 3});
    endtask

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_all4();
        test_fairness();
        test_backpressure();
        test_extremes();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
